// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes and FSM state encodings shared by alu_seq RTL and bench
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_NAND  = 3'b001;
    localparam logic [2:0] OP_SLT   = 3'b010;
    localparam logic [2:0] OP_SHIFT = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
// master drives operands and OUT_READY; slave (the ALU) drives IN_READY and the result.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   SHAMT;
    logic [2:0]       OP;
    logic             SUB;
    logic             ARI;
    logic             LEF;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] C;
    logic             ZERO;
    logic             OVF;
    logic             ILL;

    modport master (
        output IN_VALID, A, B, SHAMT, OP, SUB, ARI, LEF, OUT_READY,
        input  IN_READY, OUT_VALID, C, ZERO, OVF, ILL
    );

    modport slave (
        input  IN_VALID, A, B, SHAMT, OP, SUB, ARI, LEF, OUT_READY,
        output IN_READY, OUT_VALID, C, ZERO, OVF, ILL
    );

endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one partial product per cycle
// DONE pulses on the edge the last partial product lands; P is the low WIDTH bits of A*B.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] P
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a    <= '0;
            r_b    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (START) begin
                r_a    <= A;
                r_b    <= B;
                r_p    <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_b[0]) begin
                    r_p <= r_p + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;
    assign P    = r_p;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready handshakes on both sides
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for op 100; otherwise op 100 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic     CLK,
    input  logic     RST,
    alu_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_c;
    logic             r_zero;
    logic             r_ovf;
    logic             r_ill;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_load_alu;
    logic             w_load_mul;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_p;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_c;
    logic             w_zero;
    logic             w_ovf;
    logic             w_ill;

    assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.OUT_READY);
    assign w_accept   = bus.IN_VALID && w_in_ready;

`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul = (bus.OP == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .CLK   (CLK),
        .RST   (RST),
        .START (w_mul_start),
        .A     (bus.A),
        .B     (bus.B),
        .BUSY  (w_mul_busy),
        .DONE  (w_mul_done),
        .P     (w_mul_p)
    );
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_busy = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_p    = '0;
`endif

    // Subtraction as A + ~B + 1 so the overflow rule compares A against the inverted B.
    assign w_b_eff = bus.SUB ? ~bus.B : bus.B;
    assign w_sum   = bus.A + w_b_eff + {{(WIDTH-1){1'b0}}, bus.SUB};

    always_comb begin
        w_c   = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (bus.OP)
            OP_ADD: begin
                w_c   = w_sum;
                w_ovf = (bus.A[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_NAND: w_c = ~(bus.A & bus.B);
            OP_SLT:  w_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SHIFT: begin
                if (bus.LEF) begin
                    w_c = bus.A << bus.SHAMT;
                end else if (bus.ARI) begin
                    w_c = $signed(bus.A) >>> bus.SHAMT;
                end else begin
                    w_c = bus.A >> bus.SHAMT;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_zero = (w_c == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_alu   = 1'b0;
        w_load_mul   = 1'b0;
        w_mul_start  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_next = ST_MUL;
                        w_mul_start  = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                        w_load_alu   = 1'b1;
                    end
                end else if ((r_state == ST_DONE) && bus.OUT_READY) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_mul_done && !w_mul_busy) begin
                    w_state_next = ST_DONE;
                    w_load_mul   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result registers only move on a load, so they hold while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_c    <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_ill  <= 1'b0;
        end else if (w_load_alu) begin
            r_c    <= w_c;
            r_zero <= w_zero;
            r_ovf  <= w_ovf;
            r_ill  <= w_ill;
        end else if (w_load_mul) begin
            r_c    <= w_mul_p;
            r_zero <= (w_mul_p == '0);
            r_ovf  <= 1'b0;
            r_ill  <= 1'b0;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = (r_state == ST_DONE);
    assign bus.C         = r_c;
    assign bus.ZERO      = r_zero;
    assign bus.OVF       = r_ovf;
    assign bus.ILL       = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=16 and WIDTH=32 (honours ALU_SEQ_MUL_EN)
module tb_alu_seq;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] c;
        bit          zero;
        bit          ovf;
        bit          ill;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq_if #(.WIDTH(16)) bus16 ();
    alu_seq_if #(.WIDTH(32)) bus32 ();

    alu_seq #(.WIDTH(16)) u_dut16 (.CLK(clk), .RST(rst), .bus(bus16.slave));
    alu_seq #(.WIDTH(32)) u_dut32 (.CLK(clk), .RST(rst), .bus(bus32.slave));

    always #5 clk = ~clk;

    function automatic longint sx(input int w, input longint unsigned v);
        longint unsigned m = 64'd1 << w;
        if (v[w-1]) return longint'(v - m);
        return longint'(v);
    endfunction

    // Reference: signed/unsigned integer arithmetic reduced modulo 2^w.
    function automatic res_t model(input int w, input int op, input longint unsigned a,
                                   input longint unsigned b, input int sh,
                                   input bit sub, input bit ari, input bit lef);
        res_t            r;
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint          sa = sx(w, a);
        longint          sb = sx(w, b);
        longint          hi = (longint'(1) <<< (w - 1)) - 1;
        longint          lo = -(longint'(1) <<< (w - 1));
        longint          full;
        r = '{c: 64'd0, zero: 1'b0, ovf: 1'b0, ill: 1'b0, lat: 1};
        case (op)
            0: begin
                full  = sub ? (sa - sb) : (sa + sb);
                r.c   = full & mask;
                r.ovf = (full > hi) || (full < lo);
            end
            1: r.c = ~(a & b) & mask;
            2: r.c = (sa < sb) ? 64'd1 : 64'd0;
            3: begin
                if (lef)      r.c = (a << sh) & mask;
                else if (ari) r.c = (sa >>> sh) & mask;
                else          r.c = a >> sh;
            end
            4: begin
                if (MUL_EN) begin
                    r.c   = (a * b) & mask;
                    r.lat = w + 1;
                end else begin
                    r.ill = 1'b1;
                end
            end
            default: r.ill = 1'b1;
        endcase
        r.zero = (r.c == 64'd0);
        return r;
    endfunction

    task automatic drive_in(input int w, input int op, input longint unsigned a,
                            input longint unsigned b, input int sh,
                            input bit sub, input bit ari, input bit lef);
        if (w == 16) begin
            bus16.OP = 3'(op); bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.SHAMT = 4'(sh);
            bus16.SUB = sub; bus16.ARI = ari; bus16.LEF = lef; bus16.IN_VALID = 1'b1;
        end else begin
            bus32.OP = 3'(op); bus32.A = a[31:0]; bus32.B = b[31:0]; bus32.SHAMT = 5'(sh);
            bus32.SUB = sub; bus32.ARI = ari; bus32.LEF = lef; bus32.IN_VALID = 1'b1;
        end
    endtask

    task automatic set_valid(input int w, input bit v);
        if (w == 16) bus16.IN_VALID = v; else bus32.IN_VALID = v;
    endtask

    task automatic set_ready(input int w, input bit v);
        if (w == 16) bus16.OUT_READY = v; else bus32.OUT_READY = v;
    endtask

    function automatic bit in_ready(input int w);
        return (w == 16) ? bus16.IN_READY : bus32.IN_READY;
    endfunction

    function automatic bit out_valid(input int w);
        return (w == 16) ? bus16.OUT_VALID : bus32.OUT_VALID;
    endfunction

    function automatic res_t get_res(input int w);
        res_t r;
        if (w == 16) r = '{c: 64'(bus16.C), zero: bus16.ZERO, ovf: bus16.OVF, ill: bus16.ILL, lat: 0};
        else         r = '{c: 64'(bus32.C), zero: bus32.ZERO, ovf: bus32.OVF, ill: bus32.ILL, lat: 0};
        return r;
    endfunction

    // Starts just after a rising edge; returns just after the edge that consumes the result.
    task automatic run_op(input int w, input int op, input longint unsigned a,
                          input longint unsigned b, input int sh, input bit sub,
                          input bit ari, input bit lef, output res_t got, output bit tmo);
        int   k;
        res_t o;
        tmo = 1'b0;
        got = '{c: 64'd0, zero: 1'b0, ovf: 1'b0, ill: 1'b0, lat: 0};
        set_ready(w, 1'b1);
        drive_in(w, op, a, b, sh, sub, ari, lef);
        k = 0;
        @(negedge clk);
        while (!in_ready(w) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready(w)) begin
            tmo = 1'b1;
            set_valid(w, 1'b0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        set_valid(w, 1'b0);
        do begin
            @(negedge clk);
            got.lat++;
            if (MUL_EN && op == 4 && !out_valid(w)) begin
                n_checks++;
                if (in_ready(w) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mul_in_ready_w%0d: got %0b want 0 at cycle %0d", w, in_ready(w), got.lat);
                end
            end
        end while (!out_valid(w) && got.lat < 100);
        if (!out_valid(w)) tmo = 1'b1;
        o = get_res(w);
        got.c = o.c; got.zero = o.zero; got.ovf = o.ovf; got.ill = o.ill;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        res_t o;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int w = (i == 0) ? 16 : 32;
            o = get_res(w);
            n_checks++;
            if ({out_valid(w), in_ready(w), o.c, o.zero, o.ovf, o.ill} !== {1'b0, 1'b1, 64'd0, 3'b000}) begin
                n_fail++;
                $display("FAIL reset_w%0d: got ov=%0b ir=%0b c=%h z=%0b o=%0b i=%0b want ov=0 ir=1 c=0 flags=0",
                         w, out_valid(w), in_ready(w), o.c, o.zero, o.ovf, o.ill);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add_sub();
        longint unsigned ta[4] = '{64'd53, 64'd1938, 64'h7FFF, 64'd5};
        longint unsigned tb[4] = '{64'd69, 64'd7687, 64'd1, 64'd5};
        bit              ts[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        longint unsigned tc[4] = '{64'd122, 64'hE98B, 64'h8000, 64'd0};
        bit              tz[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit              tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        res_t got;
        bit   tmo;
        for (int i = 0; i < 4; i++) begin
            run_op(16, 0, ta[i], tb[i], 0, ts[i], 1'b0, 1'b0, got, tmo);
            n_checks++;
            if (tmo || {got.c, got.zero, got.ovf, got.ill, got.lat} !== {tc[i], tz[i], tv[i], 1'b0, 32'd1}) begin
                n_fail++;
                $display("FAIL add_sub_%0d: got c=%h z=%0b o=%0b i=%0b lat=%0d tmo=%0b want c=%h z=%0b o=%0b i=0 lat=1",
                         i, got.c, got.zero, got.ovf, got.ill, got.lat, tmo, tc[i], tz[i], tv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_c[3] = '{16'hFFFA, 16'h0001, 16'hFE22};
        res_t got;
        bit   tmo;
        bus16.OUT_READY = 1'b1;
        drive_in(16, 1, 64'h0015, 64'h0007, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0)      drive_in(16, 2, 64'hFFFF, 64'd100, 0, 1'b0, 1'b0, 1'b0);
            else if (i == 1) drive_in(16, 3, 64'h8888, 64'd0, 6, 1'b0, 1'b1, 1'b0);
            else             set_valid(16, 1'b0);
            @(negedge clk);
            n_checks++;
            if ({bus16.OUT_VALID, bus16.IN_READY, bus16.C} !== {1'b1, 1'b1, exp_c[i]}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got ov=%0b ir=%0b c=%h want ov=1 ir=1 c=%h",
                         i, bus16.OUT_VALID, bus16.IN_READY, bus16.C, exp_c[i]);
            end
        end
        @(posedge clk); #1;
        run_op(16, 3, 64'h0013, 64'd0, 4, 1'b0, 1'b0, 1'b1, got, tmo);
        n_checks++;
        if (tmo || got.c !== 64'h0130 || got.lat !== 1) begin
            n_fail++;
            $display("FAIL shift_left: got c=%h lat=%0d tmo=%0b want c=0130 lat=1", got.c, got.lat, tmo);
        end
    endtask

    task automatic test_backpressure();
        bus16.OUT_READY = 1'b0;
        drive_in(16, 0, 64'd1000, 64'd234, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus16.IN_READY !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle_ready: got %0b want 1", bus16.IN_READY);
        end
        @(posedge clk); #1;
        drive_in(16, 0, 64'd100, 64'd300, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus16.OUT_VALID, bus16.IN_READY, bus16.C} !== {1'b1, 1'b0, 16'd1234}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got ov=%0b ir=%0b c=%h want ov=1 ir=0 c=04d2",
                         i, bus16.OUT_VALID, bus16.IN_READY, bus16.C);
            end
        end
        @(posedge clk); #1;
        bus16.OUT_READY = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus16.OUT_VALID, bus16.IN_READY, bus16.C} !== {1'b1, 1'b1, 16'd1234}) begin
            n_fail++;
            $display("FAIL bp_release: got ov=%0b ir=%0b c=%h want ov=1 ir=1 c=04d2",
                     bus16.OUT_VALID, bus16.IN_READY, bus16.C);
        end
        @(posedge clk); #1;
        set_valid(16, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus16.OUT_VALID, bus16.C} !== {1'b1, 16'hFF38}) begin
            n_fail++;
            $display("FAIL bp_second: got ov=%0b c=%h want ov=1 c=ff38", bus16.OUT_VALID, bus16.C);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul(input int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned ta[2];
        longint unsigned tb[2];
        longint unsigned tc[2];
        bit              tz;
        bit              ti;
        int              tl;
        res_t            got;
        bit              tmo;
        ta = '{64'd300, mask};
        tb = '{64'd7, mask};
`ifdef ALU_SEQ_MUL_EN
        tc = '{64'd2100, 64'd1};
        tz = 1'b0; ti = 1'b0; tl = w + 1;
`else
        tc = '{64'd0, 64'd0};
        tz = 1'b1; ti = 1'b1; tl = 1;
`endif
        for (int i = 0; i < 2; i++) begin
            run_op(w, 4, ta[i], tb[i], 0, 1'b0, 1'b0, 1'b0, got, tmo);
            n_checks++;
            if (tmo || {got.c, got.zero, got.ovf, got.ill, got.lat} !== {tc[i], tz, 1'b0, ti, tl}) begin
                n_fail++;
                $display("FAIL mul_w%0d_%0d: got c=%h z=%0b o=%0b i=%0b lat=%0d tmo=%0b want c=%h z=%0b o=0 i=%0b lat=%0d",
                         w, i, got.c, got.zero, got.ovf, got.ill, got.lat, tmo, tc[i], tz, ti, tl);
            end
        end
    endtask

    task automatic test_width32();
        longint unsigned tc[2] = '{64'd122, 64'hFFFFE98B};
        longint unsigned ta[2] = '{64'd53, 64'd1938};
        longint unsigned tb[2] = '{64'd69, 64'd7687};
        res_t got;
        bit   tmo;
        for (int i = 0; i < 2; i++) begin
            run_op(32, 0, ta[i], tb[i], 0, 1'(i), 1'b0, 1'b0, got, tmo);
            n_checks++;
            if (tmo || {got.c, got.zero, got.ovf, got.ill, got.lat} !== {tc[i], 3'b000, 32'd1}) begin
                n_fail++;
                $display("FAIL w32_addsub_%0d: got c=%h z=%0b o=%0b i=%0b lat=%0d tmo=%0b want c=%h flags=0 lat=1",
                         i, got.c, got.zero, got.ovf, got.ill, got.lat, tmo, tc[i]);
            end
        end
        test_mul(32);
    endtask

    task automatic test_reset_mid_mul();
        res_t o;
        bit   seen;
        res_t got;
        bit   tmo;
        bus16.OUT_READY = 1'b0;
        drive_in(16, 4, 64'd300, 64'd7, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        set_valid(16, 1'b0);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        o = get_res(16);
        n_checks++;
        if ({bus16.OUT_VALID, bus16.IN_READY, o.c, o.zero, o.ovf, o.ill} !== {1'b0, 1'b1, 64'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got ov=%0b ir=%0b c=%h z=%0b o=%0b i=%0b want ov=0 ir=1 c=0 flags=0",
                     bus16.OUT_VALID, bus16.IN_READY, o.c, o.zero, o.ovf, o.ill);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus16.OUT_VALID) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_out_valid: got %0b want 0", seen);
        end
        @(posedge clk); #1;
        run_op(16, 0, 64'd53, 64'd69, 0, 1'b0, 1'b0, 1'b0, got, tmo);
        n_checks++;
        if (tmo || {got.c, got.zero, got.ovf, got.ill, got.lat} !== {64'd122, 3'b000, 32'd1}) begin
            n_fail++;
            $display("FAIL rst_then_add: got c=%h lat=%0d tmo=%0b want c=007a lat=1", got.c, got.lat, tmo);
        end
    endtask

    task automatic test_random();
        res_t got;
        res_t exp;
        bit   tmo;
        for (int i = 0; i < 80; i++) begin
            int              w = (i % 2) ? 32 : 16;
            longint unsigned mask = (64'd1 << w) - 64'd1;
            longint unsigned corner[4];
            longint unsigned a;
            longint unsigned b;
            int              op = $urandom_range(0, 7);
            int              sh = $urandom_range(0, w - 1);
            bit              sub = 1'($urandom);
            bit              ari = 1'($urandom);
            bit              lef = 1'($urandom);
            corner = '{64'd0, mask, 64'd1 << (w - 1), (64'd1 << (w - 1)) - 64'd1};
            a = {32'($urandom), 32'($urandom)} & mask;
            b = {32'($urandom), 32'($urandom)} & mask;
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) b = corner[$urandom_range(0, 3)];
            exp = model(w, op, a, b, sh, sub, ari, lef);
            run_op(w, op, a, b, sh, sub, ari, lef, got, tmo);
            n_checks++;
            if (tmo || {got.c, got.zero, got.ovf, got.ill, got.lat} !== {exp.c, exp.zero, exp.ovf, exp.ill, exp.lat}) begin
                n_fail++;
                $display("FAIL rand_%0d w%0d op%0d a=%h b=%h sh=%0d s/a/l=%0b%0b%0b: got c=%h z=%0b o=%0b i=%0b lat=%0d tmo=%0b want c=%h z=%0b o=%0b i=%0b lat=%0d",
                         i, w, op, a, b, sh, sub, ari, lef, got.c, got.zero, got.ovf, got.ill, got.lat, tmo,
                         exp.c, exp.zero, exp.ovf, exp.ill, exp.lat);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus16.IN_VALID = 1'b0; bus16.OUT_READY = 1'b0; bus16.A = '0; bus16.B = '0;
        bus16.SHAMT = '0; bus16.OP = '0; bus16.SUB = 1'b0; bus16.ARI = 1'b0; bus16.LEF = 1'b0;
        bus32.IN_VALID = 1'b0; bus32.OUT_READY = 1'b0; bus32.A = '0; bus32.B = '0;
        bus32.SHAMT = '0; bus32.OP = '0; bus32.SUB = 1'b0; bus32.ARI = 1'b0; bus32.LEF = 1'b0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_mul(16);
        test_reset_mid_mul();
        test_width32();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
